// File: rtl/screen_pkg.sv
// screen_pkg: shared phase encoding and overlay layer masks for the
// phase sequencer and the RGB compositor.
package screen_pkg;

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    PLAY  = 3'd1,
    HIT   = 3'd2,
    DYING = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } phase_t;

  localparam int LAYER_TITLE   = 0;
  localparam int LAYER_HUD     = 1;
  localparam int LAYER_PLAYER  = 2;
  localparam int LAYER_MONSTER = 3;
  localparam int LAYER_WALL    = 4;
  localparam int LAYER_OVER    = 5;
  localparam int LAYER_WIN     = 6;
  localparam int LAYER_N       = 7;

  localparam logic [LAYER_N-1:0] MASK_TITLE = 7'b0000001;
  localparam logic [LAYER_N-1:0] MASK_PLAY  = 7'b0011110;
  localparam logic [LAYER_N-1:0] MASK_HIT   = 7'b0011110;
  localparam logic [LAYER_N-1:0] MASK_DYING = 7'b0011010;
  localparam logic [LAYER_N-1:0] MASK_OVER  = 7'b0111010;
  localparam logic [LAYER_N-1:0] MASK_WIN   = 7'b1011010;

  // Bits needed to hold a down-count of n-1 .. 0.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter, one step per tick, holds at zero.
// Ports: clk, rst (async high), tick, load, load_val -> count, zero.
module frame_timer
  import screen_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/screen_phase_ctrl.sv
// screen_phase_ctrl: frame-synchronous game phase sequencer; owns
// hearts/level and the per-phase overlay enables.
// Ports: clk, rst (async high), frame_start, key_start, player_hit,
//   level_clear -> phase[2:0], layer_en[6:0], blink_on, hearts[1:0],
//   level[3:0], game_rst.
module screen_phase_ctrl
  import screen_pkg::*;
#(
  parameter int BLINK_FRAMES      = 30,
  parameter int HIT_FLASH_FRAMES  = 60,
  parameter int DEATH_HOLD_FRAMES = 90,
  parameter int MAX_HEARTS        = 3,
  parameter int WIN_LEVEL         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       key_start,
  input  logic       player_hit,
  input  logic       level_clear,
  output logic [2:0] phase,
  output logic [6:0] layer_en,
  output logic       blink_on,
  output logic [1:0] hearts,
  output logic [3:0] level,
  output logic       game_rst
);

  localparam int TW_RAW =
    (HIT_FLASH_FRAMES > DEATH_HOLD_FRAMES) ?
    cnt_w(HIT_FLASH_FRAMES) : cnt_w(DEATH_HOLD_FRAMES);
  // Flicker reads timer bit 2, so keep at least 3 bits.
  localparam int TW = (TW_RAW < 3) ? 3 : TW_RAW;
  localparam int BW = cnt_w(BLINK_FRAMES);

  localparam logic [TW-1:0] HIT_LOAD   = TW'(HIT_FLASH_FRAMES - 1);
  localparam logic [TW-1:0] DEATH_LOAD = TW'(DEATH_HOLD_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    HEARTS_MAX = 2'(MAX_HEARTS);
  localparam logic [3:0]    LEVEL_WIN  = 4'(WIN_LEVEL);

  phase_t        phase_q;
  phase_t        phase_nx;
  logic [1:0]    hearts_q;
  logic [1:0]    hearts_nx;
  logic [1:0]    hearts_dec;
  logic [3:0]    level_q;
  logic [3:0]    level_nx;
  logic [3:0]    level_inc;
  logic          at_win;
  logic          grst_q;
  logic          grst_nx;

  logic          pend_start;
  logic          pend_hit;
  logic          pend_clr;
  logic          ev_start;
  logic          ev_hit;
  logic          ev_clr;
  logic          keep_clr;

  logic          t_load;
  logic [TW-1:0] t_val;
  logic [TW-1:0] t_cnt;
  logic          t_zero;

  logic          entry;
  logic          b_load;
  logic [BW-1:0] b_cnt;
  logic          b_zero;
  logic          blink_q;

  logic          unused_bits;

  // Same-cycle events count toward the frame that is starting.
  assign ev_start = pend_start | key_start;
  assign ev_hit   = pend_hit   | player_hit;
  assign ev_clr   = pend_clr   | level_clear;

  assign hearts_dec = (hearts_q == 2'd0) ? 2'd0 : hearts_q - 2'd1;
  assign at_win     = (level_q == LEVEL_WIN);
  assign level_inc  = (level_q < LEVEL_WIN) ? level_q + 4'd1 : level_q;

  assign entry  = frame_start && (phase_nx != phase_q);
  assign b_load = frame_start && (entry || b_zero);

  frame_timer #(
    .W       (TW),
    .RST_VAL ('0)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (frame_start),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_cnt),
    .zero     (t_zero)
  );

  // Counts down from BLINK_LOAD; a zero at frame_start is a wrap.
  frame_timer #(
    .W       (BW),
    .RST_VAL (BLINK_LOAD)
  ) u_blink_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (frame_start),
    .load     (b_load),
    .load_val (BLINK_LOAD),
    .count    (b_cnt),
    .zero     (b_zero)
  );

  assign unused_bits = ^{t_cnt, b_cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= TITLE;
      hearts_q   <= 2'd0;
      level_q    <= 4'd0;
      grst_q     <= 1'b0;
      pend_start <= 1'b0;
      pend_hit   <= 1'b0;
      pend_clr   <= 1'b0;
      blink_q    <= 1'b1;
    end else begin
      grst_q <= grst_nx;
      if (frame_start) begin
        phase_q    <= phase_nx;
        hearts_q   <= hearts_nx;
        level_q    <= level_nx;
        pend_start <= 1'b0;
        pend_hit   <= 1'b0;
        pend_clr   <= keep_clr;
        if (entry) begin
          blink_q <= 1'b1;
        end else if (b_zero) begin
          blink_q <= ~blink_q;
        end
      end else begin
        pend_start <= pend_start | key_start;
        pend_hit   <= pend_hit   | player_hit;
        pend_clr   <= pend_clr   | level_clear;
      end
    end
  end

  always_comb begin
    phase_nx  = phase_q;
    hearts_nx = hearts_q;
    level_nx  = level_q;
    grst_nx   = 1'b0;
    keep_clr  = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;
    if (frame_start) begin
      unique case (phase_q)
        TITLE: begin
          if (ev_start) begin
            phase_nx  = PLAY;
            hearts_nx = HEARTS_MAX;
            level_nx  = 4'd1;
            grst_nx   = 1'b1;
          end
        end
        PLAY: begin
          if (ev_hit) begin
            hearts_nx = hearts_dec;
            // The clear is preempted, not lost.
            keep_clr  = ev_clr;
            t_load    = 1'b1;
            if (hearts_dec == 2'd0) begin
              phase_nx = DYING;
              t_val    = DEATH_LOAD;
            end else begin
              phase_nx = HIT;
              t_val    = HIT_LOAD;
            end
          end else if (ev_clr) begin
            if (at_win) begin
              phase_nx = WIN;
            end else begin
              level_nx = level_inc;
              grst_nx  = 1'b1;
            end
          end
        end
        HIT: begin
          if (ev_clr && at_win) begin
            phase_nx = WIN;
          end else begin
            if (ev_clr) begin
              level_nx = level_inc;
              grst_nx  = 1'b1;
            end
            if (t_zero) begin
              phase_nx = PLAY;
            end
          end
        end
        DYING: begin
          if (t_zero) begin
            phase_nx = OVER;
          end
        end
        OVER, WIN: begin
          if (ev_start) begin
            phase_nx  = TITLE;
            hearts_nx = 2'd0;
            level_nx  = 4'd0;
          end
        end
        default: begin
          phase_nx = TITLE;
        end
      endcase
    end
  end

  always_comb begin
    layer_en = MASK_TITLE;
    unique case (phase_q)
      TITLE: layer_en = MASK_TITLE;
      PLAY:  layer_en = MASK_PLAY;
      HIT: begin
        layer_en               = MASK_HIT;
        layer_en[LAYER_PLAYER] = ~t_cnt[2];
      end
      DYING:   layer_en = MASK_DYING;
      OVER:    layer_en = MASK_OVER;
      WIN:     layer_en = MASK_WIN;
      default: layer_en = MASK_TITLE;
    endcase
  end

  assign phase    = phase_q;
  assign hearts   = hearts_q;
  assign level    = level_q;
  assign game_rst = grst_q;
  assign blink_on = blink_q;

endmodule

// File: tb/tb_screen_phase_ctrl.sv
// tb_screen_phase_ctrl: directed stimulus, frame-level reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_screen_phase_ctrl;

  localparam int BLINK = 30;
  localparam int HITF  = 60;
  localparam int DEATH = 90;
  localparam int MAXH  = 3;
  localparam int WINL  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       key_start;
  logic       player_hit;
  logic       level_clear;
  logic [2:0] phase;
  logic [6:0] layer_en;
  logic       blink_on;
  logic [1:0] hearts;
  logic [3:0] level;
  logic       game_rst;

  int vectors = 0;
  int misc    = 0;
  bit started = 0;

  screen_phase_ctrl #(
    .BLINK_FRAMES      (BLINK),
    .HIT_FLASH_FRAMES  (HITF),
    .DEATH_HOLD_FRAMES (DEATH),
    .MAX_HEARTS        (MAXH),
    .WIN_LEVEL         (WINL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .key_start   (key_start),
    .player_hit  (player_hit),
    .level_clear (level_clear),
    .phase       (phase),
    .layer_en    (layer_en),
    .blink_on    (blink_on),
    .hearts      (hearts),
    .level       (level),
    .game_rst    (game_rst)
  );

  always #5 clk = ~clk;

  // Model: phase id, counters, and frames elapsed since phase entry.
  int m_phase, m_hearts, m_level, m_since, m_grst, nxt;
  bit m_ps, m_ph, m_pc, e_s, e_h, e_c;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_hearts = 0; m_level = 0;
      m_since = 0; m_grst = 0;
      m_ps = 0; m_ph = 0; m_pc = 0;
    end else begin
      m_grst = 0;
      if (frame_start) begin
        e_s = m_ps | key_start;
        e_h = m_ph | player_hit;
        e_c = m_pc | level_clear;
        m_ps = 0; m_ph = 0; m_pc = 0;
        nxt = m_phase;
        case (m_phase)
          0: if (e_s) begin
            nxt = 1; m_hearts = MAXH; m_level = 1; m_grst = 1;
          end
          1: begin
            if (e_h) begin
              m_hearts = (m_hearts > 0) ? m_hearts - 1 : 0;
              nxt = (m_hearts == 0) ? 3 : 2;
              m_pc = e_c;
            end else if (e_c) begin
              if (m_level == WINL) nxt = 5;
              else begin m_level++; m_grst = 1; end
            end
          end
          2: begin
            if (e_c) begin
              if (m_level == WINL) nxt = 5;
              else begin m_level++; m_grst = 1; end
            end
            if (nxt == 2 && m_since == HITF - 1) nxt = 1;
          end
          3: if (m_since == DEATH - 1) nxt = 4;
          4, 5: if (e_s) begin
            nxt = 0; m_hearts = 0; m_level = 0;
          end
          default: nxt = 0;
        endcase
        m_since = (nxt != m_phase) ? 0 : m_since + 1;
        m_phase = nxt;
      end else begin
        m_ps |= key_start;
        m_ph |= player_hit;
        m_pc |= level_clear;
      end
    end
  end

  function automatic logic [6:0] exp_layer(int p, int since);
    logic [6:0] v;
    int t;
    case (p)
      0: v = 7'b0000001;
      1: v = 7'b0011110;
      2: begin
        v = 7'b0011110;
        t = HITF - 1 - since;
        v[2] = (((t >> 2) & 1) == 0);
      end
      3: v = 7'b0011010;
      4: v = 7'b0111010;
      5: v = 7'b1011010;
      default: v = 7'bx;
    endcase
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, int exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("phase", 32'(phase), m_phase);
      chk("layer_en", 32'(layer_en), int'(exp_layer(m_phase, m_since)));
      chk("blink_on", 32'(blink_on), int'(((m_since / BLINK) % 2) == 0));
      chk("hearts", 32'(hearts), m_hearts);
      chk("level", 32'(level), m_level);
      chk("game_rst", 32'(game_rst), m_grst);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit k = 1'b0, input bit h = 1'b0,
                       input bit c = 1'b0);
    frame_start = 1; key_start = k; player_hit = h; level_clear = c;
    tick();
    frame_start = 0; key_start = 0; player_hit = 0; level_clear = 0;
    tick();
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic ev(input bit k, input bit h, input bit c);
    key_start = k; player_hit = h; level_clear = c;
    tick();
    key_start = 0; player_hit = 0; level_clear = 0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_layer"}, 32'(layer_en), 7'b0000001);
    chk({tag, "_blink"}, 32'(blink_on), 1);
    chk({tag, "_hearts"}, 32'(hearts), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_grst"}, 32'(game_rst), 0);
  endtask

  initial begin
    rst = 1; frame_start = 0; key_start = 0;
    player_hit = 0; level_clear = 0;
    tick();
    tick();
    chk_reset_vals("rst");
    rst = 0;
    started = 1;
    tick();

    // start: pending key consumed at next frame
    ev(1, 0, 0);
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("t1_grst_hi", 32'(game_rst), 1);
    chk("t1_phase", 32'(phase), 1);
    chk("t1_hearts", 32'(hearts), 3);
    chk("t1_level", 32'(level), 1);
    chk("t1_layer", 32'(layer_en), 7'b0011110);
    tick();
    chk("t1_grst_lo", 32'(game_rst), 0);
    tick();

    // three hits to death
    frame(0, 1, 0);
    chk("t2_h2", 32'(hearts), 2);
    chk("t2_hit1", 32'(phase), 2);
    frames(60);
    chk("t2_play1", 32'(phase), 1);
    frame(0, 1, 0);
    chk("t2_h1", 32'(hearts), 1);
    chk("t2_hit2", 32'(phase), 2);
    frames(60);
    chk("t2_play2", 32'(phase), 1);
    frame(0, 1, 0);
    chk("t2_h0", 32'(hearts), 0);
    chk("t2_dying", 32'(phase), 3);
    chk("t2_dlayer", 32'(layer_en), 7'b0011010);
    frames(89);
    chk("t2_still_dying", 32'(phase), 3);
    frame();
    chk("t2_over", 32'(phase), 4);
    chk("t2_olayer", 32'(layer_en), 7'b0111010);

    // back to title, restart
    frame(1, 0, 0);
    chk("t3_title", 32'(phase), 0);
    chk("t3_lvl0", 32'(level), 0);
    frame(1, 0, 0);
    chk("t3_play", 32'(phase), 1);

    // hit and clear together: clear deferred one frame
    frame(0, 1, 1);
    chk("t3_hearts", 32'(hearts), 2);
    chk("t3_hit", 32'(phase), 2);
    chk("t3_lvl_same", 32'(level), 1);
    frame();
    chk("t3_lvl_next", 32'(level), 2);
    chk("t3_still_hit", 32'(phase), 2);
    frame(0, 1, 0);
    chk("t3_hit_ignored", 32'(hearts), 2);
    chk("t3_lvl_stable", 32'(level), 2);

    // clears to WIN
    ev(0, 0, 1);
    frame();
    chk("t4_lvl3", 32'(level), 3);
    frames(57);
    chk("t4_play", 32'(phase), 1);
    frame(0, 0, 1);
    chk("t4_lvl4", 32'(level), 4);
    frame(0, 0, 1);
    chk("t4_win", 32'(phase), 5);
    chk("t4_wlayer", 32'(layer_en), 7'b1011010);
    chk("t4_wlvl", 32'(level), 4);
    frame(1, 0, 0);
    chk("t4_title", 32'(phase), 0);
    chk("t4_hearts0", 32'(hearts), 0);
    chk("t4_level0", 32'(level), 0);
    chk("t4_tlayer", 32'(layer_en), 7'b0000001);

    // title blink
    frames(29);
    chk("t5_blink29", 32'(blink_on), 1);
    frame();
    chk("t5_blink30", 32'(blink_on), 0);
    frames(29);
    chk("t5_blink59", 32'(blink_on), 0);
    frame();
    chk("t5_blink60", 32'(blink_on), 1);
    ev(1, 0, 0);
    tick();
    chk("t5_no_frame", 32'(phase), 0);

    // reset during HIT
    frame();
    chk("t6_play", 32'(phase), 1);
    frame(0, 1, 0);
    chk("t6_hit", 32'(phase), 2);
    ev(1, 1, 0);
    rst = 1;
    #1;
    chk_reset_vals("t6");
    tick();
    rst = 0;
    frame();
    chk("t6_lost_phase", 32'(phase), 0);
    chk("t6_lost_hearts", 32'(hearts), 0);
    frames(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
